// File: rtl/cfglut5_init_loader.sv
// cfglut5_init_loader
//   Reprograms CFGLUT5 dynamic LUTs at run time. A 32-bit INIT image taken
//   from a valid/ready request is shifted MSB first into one of NUM_LUTS
//   CFGLUT5 instances over a shared CDI line, using that instance's own CE.
//
// Ports
//   i_clk        clock shared with the CFGLUT5 array
//   i_rst        synchronous active-high reset
//   i_req_valid  load request valid
//   o_req_ready  loader can accept a request
//   i_req_sel    index of the target LUT
//   i_req_init   new INIT image (bit n = LUT output for address n)
//   o_ce         per-LUT shift enable, one-hot or zero
//   o_cdi        shared serial configuration data
//   o_busy       shift sequence in progress
//   o_done       one-cycle pulse at the end of every accepted request
//   o_err        pulses with o_done when i_req_sel >= NUM_LUTS
//
// Optional readback (macro CFGLUT5_INIT_LOADER_READBACK_EN)
//   i_cdo        CDO outputs of the CFGLUT5 array
//   o_rd_init    previous INIT image of the last reloaded LUT
//
// States
//   S_IDLE  | ready for a request
//   S_SHIFT | 32 cycles shifting the image into the selected LUT
//   S_DONE  | one-cycle completion pulse (with ERR for a bad select)

module cfglut5_init_loader #(
  parameter int NUM_LUTS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [SEL_W-1:0]    i_req_sel,
  input  logic [31:0]         i_req_init,
  output logic [NUM_LUTS-1:0] o_ce,
  output logic                o_cdi,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
  ,
  input  logic [NUM_LUTS-1:0] i_cdo,
  output logic [31:0]         o_rd_init
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [4:0]          r_cnt, w_cnt_nxt;
  logic [31:0]         r_sh, w_sh_nxt;
  logic [SEL_W-1:0]    r_sel, w_sel_nxt;
  logic [NUM_LUTS-1:0] r_ce, w_ce_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                w_sel_ok;

  assign w_sel_ok = (32'(i_req_sel) < 32'(NUM_LUTS));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_sel_nxt   = r_sel;
    w_ce_nxt    = '0;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid && r_ready) begin
          w_sel_nxt = i_req_sel;
          w_cnt_nxt = 5'd0;
          if (w_sel_ok) begin
            w_state_nxt = S_SHIFT;
            w_sh_nxt    = i_req_init;
            w_ce_nxt    = NUM_LUTS'(1) << i_req_sel;
            w_busy_nxt  = 1'b1;
          end else begin
            // bad select: accepted, but nothing is shifted and CDI stays 0
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_SHIFT: begin
        // CDI is the MSB of this register, so shifting left walks MSB first
        w_sh_nxt = {r_sh[30:0], 1'b0};
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt  = r_cnt + 5'd1;
          w_ce_nxt   = r_ce;
          w_busy_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_sh    <= 32'd0;
      r_sel   <= '0;
      r_ce    <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_sel   <= w_sel_nxt;
      r_ce    <= w_ce_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_req_ready = r_ready;
  assign o_ce        = r_ce;
  assign o_cdi       = r_sh[31];
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
  logic [31:0] r_rd_init;

  // CDO is the LUT's current MSB; sampling it on each enabled edge
  // collects the old image while the new one is shifted in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_init <= 32'd0;
    end else if (r_state == S_SHIFT) begin
      r_rd_init <= {r_rd_init[30:0], i_cdo[r_sel]};
    end
  end

  assign o_rd_init = r_rd_init;
`endif

endmodule

// File: tb/tb_cfglut5_init_loader.sv
module tb_cfglut5_init_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = 2'd0;
  logic [31:0] req_init = 32'd0;
  logic [3:0]  ce;
  logic        cdi, busy, done, err;

  logic        valid3 = 1'b0;
  logic        ready3;
  logic [1:0]  sel3 = 2'd0;
  logic [31:0] init3 = 32'd0;
  logic [2:0]  ce3;
  logic        cdi3, busy3, done3, err3;

`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
  logic [3:0]  cdo;
  logic [31:0] rd_init;
  logic [31:0] rd_init3;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_q[$];
  int n_done   = 0;
  int n_multi  = 0;
  int n_ce3    = 0;

  // behavioural CFGLUT5 array and the images the bench expects it to hold
  logic [31:0] lut     [4] = '{32'hA5A5_0F0F, 32'h1357_9BDF, 32'h0246_8ACE, 32'hDEAD_BEEF};
  logic [31:0] exp_lut [4] = '{32'hA5A5_0F0F, 32'h1357_9BDF, 32'h0246_8ACE, 32'hDEAD_BEEF};

  always #5 clk = ~clk;

  cfglut5_init_loader #(.NUM_LUTS(4), .SEL_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_sel(req_sel), .i_req_init(req_init), .o_ce(ce), .o_cdi(cdi),
    .o_busy(busy), .o_done(done), .o_err(err)
`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
    , .i_cdo(cdo), .o_rd_init(rd_init)
`endif
  );

  cfglut5_init_loader #(.NUM_LUTS(3), .SEL_W(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid3), .o_req_ready(ready3),
    .i_req_sel(sel3), .i_req_init(init3), .o_ce(ce3), .o_cdi(cdi3),
    .o_busy(busy3), .o_done(done3), .o_err(err3)
`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
    , .i_cdo(3'b000), .o_rd_init(rd_init3)
`endif
  );

`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
  assign cdo = {lut[3][31], lut[2][31], lut[1][31], lut[0][31]};
`endif

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ce[i] === 1'b1) lut[i] <= {lut[i][30:0], cdi};
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (req_valid === 1'b1 && req_ready === 1'b1) hs_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if ($countones(ce) > 1) n_multi++;
    if (ce3 !== 3'b000) n_ce3++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // returns in the first cycle after the handshake edge
  task automatic handshake(input logic [1:0] s, input logic [31:0] d);
    req_valid = 1'b1;
    req_sel   = s;
    req_init  = d;
    for (int t = 0; t < 100 && req_ready !== 1'b1; t++) @(negedge clk);
    chk("hs_ready", req_ready, 1);
    @(negedge clk);
  endtask

  // called in cycle k+1 of an accepted valid load; returns in cycle k+34
  task automatic run_shift(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] seq;
    int ce_ok, busy_ok, rdy_hi;
    seq = 32'd0; ce_ok = 0; busy_ok = 0; rdy_hi = 0;
    for (int j = 0; j < 32; j++) begin
      seq = {seq[30:0], cdi};
      if (ce === (4'b0001 << s)) ce_ok++;
      if (busy === 1'b1) busy_ok++;
      if (req_ready !== 1'b0) rdy_hi++;
      @(negedge clk);
    end
    chk("cdi_seq", seq, d);
    chk("ce_cycles", ce_ok, 32);
    chk("busy_cycles", busy_ok, 32);
    chk("ready_low_shift", rdy_hi, 0);
    chk("done_pulse", done, 1);
    chk("err_clear", err, 0);
    chk("ce_at_done", ce, 0);
    chk("busy_at_done", busy, 0);
    chk("ready_at_done", req_ready, 0);
`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
    chk("rd_init_old", rd_init, exp_lut[s]);
`endif
    exp_lut[s] = d;
    @(negedge clk);
    chk("ready_back", req_ready, 1);
    chk("done_single", done, 0);
    for (int i = 0; i < 4; i++) chk("lut_image", lut[i], exp_lut[i]);
  endtask

  initial begin
    logic [31:0] img;
    logic [1:0]  s;
    int bad, nd;

    // reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_ce", ce, 0);
    chk("rst_cdi", cdi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready3", ready3, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // first load with a second request held behind it
    hs_q.delete();
    handshake(2'd2, 32'hCAFE_F00D);
    req_sel  = 2'd0;
    req_init = 32'h0000_0001;
    run_shift(2'd2, 32'hCAFE_F00D);
    img = 32'hCAFE_F00D;
    bad = 0;
    for (int a = 0; a < 32; a++) if (lut[2][a] !== img[a]) bad++;
    chk("lut2_addr_out", bad, 0);
    @(negedge clk);
    req_valid = 1'b0;
    run_shift(2'd0, 32'h0000_0001);
    chk("hs_count", hs_q.size(), 2);
    if (hs_q.size() >= 2) chk("hs_spacing", hs_q[1] - hs_q[0], 34);
    bad = 0;
    for (int a = 0; a < 32; a++) if (lut[0][a] !== (a == 0)) bad++;
    chk("lut0_nor_decode", bad, 0);

    // invalid select on a 3-LUT loader
    valid3 = 1'b1;
    sel3   = 2'd3;
    init3  = $urandom;
    for (int t = 0; t < 100 && ready3 !== 1'b1; t++) @(negedge clk);
    chk("inv_hs_ready", ready3, 1);
    @(negedge clk);
    valid3 = 1'b0;
    chk("inv_done", done3, 1);
    chk("inv_err", err3, 1);
    chk("inv_ce", ce3, 0);
    chk("inv_busy", busy3, 0);
    chk("inv_ready_low", ready3, 0);
    @(negedge clk);
    chk("inv_ready_back", ready3, 1);
    chk("inv_done_end", done3, 0);
    chk("inv_err_end", err3, 0);

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      s   = 2'($urandom_range(3, 0));
      img = $urandom;
      repeat ($urandom_range(3, 0)) @(negedge clk);
      handshake(s, img);
      req_valid = 1'b0;
      run_shift(s, img);
    end

    // reset at shift count 10
    handshake(2'd1, $urandom);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_ce", ce, 4'b0010);
    nd  = n_done;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ce", ce, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    repeat (40) @(negedge clk);
    chk("abort_no_done", n_done, nd);
    exp_lut[1] = lut[1];
    handshake(2'd1, 32'hFFFF_FFFF);
    req_valid = 1'b0;
    run_shift(2'd1, 32'hFFFF_FFFF);

    // reload the same LUT twice, then idle
    handshake(2'd3, 32'h1234_5678);
    req_valid = 1'b0;
    run_shift(2'd3, 32'h1234_5678);
    handshake(2'd3, 32'h0000_0000);
    req_valid = 1'b0;
    run_shift(2'd3, 32'h0000_0000);
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      req_sel  = 2'($urandom_range(3, 0));
      req_init = $urandom;
      @(negedge clk);
      if (req_ready !== 1'b1 || ce !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad++;
`ifdef CFGLUT5_INIT_LOADER_READBACK_EN
      if (rd_init !== 32'h1234_5678) bad++;
`endif
    end
    chk("idle_bad_cycles", bad, 0);

    chk("multi_ce_cycles", n_multi, 0);
    chk("ce3_cycles", n_ce3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
